// File: rtl/alu_sequencer.sv
// alu_sequencer: bus-side initiator for an 8-bit, 16-op combinational ALU.
// Buffers requests in a small FIFO. Each request is presented to the ALU, and
// the operands are held for a settle window. The tri-state result bus is
// enabled (alu_oe) for exactly one cycle and captured. Results are returned
// in order over a valid/ready channel. Divide-by-zero is answered locally
// with rsp_data=16'hFFFF and rsp_err=1, without enabling the ALU.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (req_ready = FIFO not full)
//   req_cmd/req_a/req_b        requested opcode and operands
//   alu_a/alu_b/alu_cmd        operands/opcode driven to the ALU
//   alu_oe                     ALU output enable, high only in SAMPLE
//   alu_d                      ALU result bus
//   rsp_valid/rsp_ready        response handshake
//   rsp_data/rsp_err           captured result, divide-by-zero flag
//   busy                       FSM active or requests queued
module alu_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned SETTLE_LONG = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_cmd,
    output logic        alu_oe,
    input  logic [15:0] alu_d,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned OP_W    = 8;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCNT_W  = PTR_W + 1;
    localparam int unsigned CNT_MAX = (SETTLE > SETTLE_LONG) ? SETTLE : SETTLE_LONG;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CMD_W-1:0] CMD_MUL = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_DIV = 4'b0101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state, state_next;

    // Request FIFO storage and pointers
    logic [CMD_W-1:0]  fifo_cmd [DEPTH];
    logic [OP_W-1:0]   fifo_a   [DEPTH];
    logic [OP_W-1:0]   fifo_b   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] count;
    logic [FCNT_W-1:0] count_next;

    logic              push;
    logic              pop;
    logic              fifo_empty;

    logic [CMD_W-1:0]  head_cmd;
    logic [OP_W-1:0]   head_a;
    logic [OP_W-1:0]   head_b;
    logic              head_div0;
    logic [CNT_W-1:0]  head_settle_m1;

    // Settle counter and operation state
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              div0, div0_next;
    logic              load_alu;
    logic [DATA_W-1:0] rsp_data_next;
    logic              rsp_err_next;

    assign push       = req_valid && req_ready;
    assign fifo_empty = (count == FCNT_W'(0));

    assign head_cmd  = fifo_cmd[rd_ptr];
    assign head_a    = fifo_a[rd_ptr];
    assign head_b    = fifo_b[rd_ptr];
    assign head_div0 = (head_cmd == CMD_DIV) && (head_b == OP_W'(0));

    // MUL/DIV get the long settle window
    assign head_settle_m1 = ((head_cmd == CMD_MUL) || (head_cmd == CMD_DIV))
                          ? CNT_W'(SETTLE_LONG - 1)
                          : CNT_W'(SETTLE - 1);

    // FIFO payload write (no reset needed on storage)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr] <= req_cmd;
            fifo_a[wr_ptr]   <= req_a;
            fifo_b[wr_ptr]   <= req_b;
        end
    end

    // FIFO occupancy; simultaneous push and pop leaves count unchanged
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + FCNT_W'(1);
            2'b01:   count_next = count - FCNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and datapath control
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        load_alu      = 1'b0;
        cnt_next      = cnt;
        div0_next     = div0;
        rsp_data_next = rsp_data;
        rsp_err_next  = rsp_err;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    load_alu   = !head_div0;
                    div0_next  = head_div0;
                    cnt_next   = head_settle_m1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                // Divide-by-zero passes through one DRIVE cycle with the ALU
                // inputs untouched and oe low, which gives it a 2-edge latency.
                if (div0) begin
                    rsp_data_next = 16'hFFFF;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end else if (cnt == CNT_W'(0)) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            SAMPLE: begin
                rsp_data_next = alu_d;
                rsp_err_next  = 1'b0;
                state_next    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered datapath and outputs, derived from next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            div0      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cmd   <= '0;
            alu_oe    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            cnt  <= cnt_next;
            div0 <= div0_next;
            if (load_alu) begin
                alu_a   <= head_a;
                alu_b   <= head_b;
                alu_cmd <= head_cmd;
            end
            alu_oe    <= (state_next == SAMPLE);
            rsp_valid <= (state_next == RESP);
            rsp_data  <= rsp_data_next;
            rsp_err   <= rsp_err_next;
            busy      <= (state_next != IDLE) || (count_next != FCNT_W'(0));
            req_ready <= (count_next != FCNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a behavioural ALU on the far side.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = 4'h0;
    logic [7:0]  req_a = 8'h00;
    logic [7:0]  req_b = 8'h00;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_oe;
    logic [15:0] alu_d;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer #(.DEPTH(4), .SETTLE(1), .SETTLE_LONG(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cmd   (alu_cmd),
        .alu_oe    (alu_oe),
        .alu_d     (alu_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; 16'hDEAD stands in for the released bus when oe is low
    logic [15:0] alu_res;
    always_comb begin
        case (alu_cmd)
            4'h0:    alu_res = {8'h00, alu_a} + {8'h00, alu_b};
            4'h1:    alu_res = {8'h00, alu_a} - {8'h00, alu_b};
            4'h2:    alu_res = {8'h00, alu_a & alu_b};
            4'h3:    alu_res = {8'h00, alu_a | alu_b};
            4'h4:    alu_res = {8'h00, alu_a} * {8'h00, alu_b};
            4'h5:    alu_res = (alu_b == 8'h00) ? 16'h0BAD : {8'h00, alu_a / alu_b};
            4'h6:    alu_res = {8'h00, alu_a ^ alu_b};
            4'h7:    alu_res = {7'b0, alu_a, 1'b0};
            default: alu_res = 16'h0000;
        endcase
        alu_d = alu_oe ? alu_res : 16'hDEAD;
    end

    // Count oe cycles and record what the ALU saw while enabled
    int         oe_cnt = 0;
    logic [7:0] oe_a = 8'h00;
    logic [7:0] oe_b = 8'h00;
    logic [3:0] oe_cmd = 4'h0;
    always @(posedge clk) begin
        if (alu_oe) begin
            oe_cnt <= oe_cnt + 1;
            oe_a   <= alu_a;
            oe_b   <= alu_b;
            oe_cmd <= alu_cmd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one op into an idle, empty sequencer and follow it to its response
    task automatic run_op(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                          output int oe_lat, output int rsp_lat, output int oe_cycles,
                          output logic [15:0] data, output logic err, output logic valid_after);
        int n;
        int oe0;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        oe0    = oe_cnt;
        n      = 0;
        oe_lat = -1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
            if (alu_oe && oe_lat < 0) oe_lat = n;
        end
        rsp_lat = rsp_valid ? n : -1;
        data    = rsp_data;
        err     = rsp_err;
        tick();
        valid_after = rsp_valid;
        oe_cycles   = oe_cnt - oe0;
    endtask

    // Push one op, waiting (bounded) for space
    task automatic push_op(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
        int n;
        req_cmd   = cmd;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({alu_oe, alu_a, alu_b, alu_cmd, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: oe=%b a=%h b=%h cmd=%h vld=%b data=%h err=%b busy=%b, all required 0",
                     alu_oe, alu_a, alu_b, alu_cmd, rsp_valid, rsp_data, rsp_err, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: req_ready=%b busy=%b, required 1/0", req_ready, busy);
        end
    endtask

    task automatic test_add();
        int oe_lat, rsp_lat, oe_cyc;
        logic [15:0] d;
        logic e, va;
        rsp_ready = 1'b1;
        run_op(4'h0, 8'h0F, 8'h01, oe_lat, rsp_lat, oe_cyc, d, e, va);
        vectors++;
        if (d !== 16'h0010 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL add_data: got %h err %b, required 0010 err 0", d, e);
        end
        vectors++;
        if (rsp_lat != 3 || oe_lat != 2) begin
            miscompares++;
            $display("FAIL add_latency: rsp %0d oe %0d, required 3 and 2", rsp_lat, oe_lat);
        end
        vectors++;
        if (oe_cyc != 1) begin
            miscompares++;
            $display("FAIL add_oe_width: %0d cycles, required 1", oe_cyc);
        end
        vectors++;
        if ({oe_cmd, oe_a, oe_b} !== {4'h0, 8'h0F, 8'h01}) begin
            miscompares++;
            $display("FAIL add_operands: cmd %h a %h b %h, required 0 0f 01", oe_cmd, oe_a, oe_b);
        end
        vectors++;
        if (va !== 1'b0) begin
            miscompares++;
            $display("FAIL add_handshake: rsp_valid %b after handshake, required 0", va);
        end
    endtask

    task automatic test_mul_div();
        int oe_lat, rsp_lat, oe_cyc;
        logic [15:0] d;
        logic e, va;
        run_op(4'h4, 8'hFF, 8'hFF, oe_lat, rsp_lat, oe_cyc, d, e, va);
        vectors++;
        if (d !== 16'hFE01 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_data: got %h err %b, required fe01 err 0", d, e);
        end
        vectors++;
        if (rsp_lat != 5 || oe_lat != 4 || oe_cyc != 1) begin
            miscompares++;
            $display("FAIL mul_timing: rsp %0d oe %0d oe_cycles %0d, required 5 4 1", rsp_lat, oe_lat, oe_cyc);
        end
        run_op(4'h5, 8'h20, 8'h04, oe_lat, rsp_lat, oe_cyc, d, e, va);
        vectors++;
        if (d !== 16'h0008 || rsp_lat != 5) begin
            miscompares++;
            $display("FAIL div_data: got %h latency %0d, required 0008 latency 5", d, rsp_lat);
        end
    endtask

    task automatic test_div0();
        int oe_lat, rsp_lat, oe_cyc;
        logic [15:0] d;
        logic e, va;
        run_op(4'h5, 8'h20, 8'h00, oe_lat, rsp_lat, oe_cyc, d, e, va);
        vectors++;
        if (d !== 16'hFFFF || e !== 1'b1) begin
            miscompares++;
            $display("FAIL div0_data: got %h err %b, required ffff err 1", d, e);
        end
        vectors++;
        if (rsp_lat != 2 || oe_cyc != 0) begin
            miscompares++;
            $display("FAIL div0_timing: latency %0d oe_cycles %0d, required 2 and 0", rsp_lat, oe_cyc);
        end
        vectors++;
        if ({alu_cmd, alu_a, alu_b} !== {4'h5, 8'h20, 8'h04}) begin
            miscompares++;
            $display("FAIL div0_alu_hold: cmd %h a %h b %h, required 5 20 04", alu_cmd, alu_a, alu_b);
        end
        run_op(4'h0, 8'h01, 8'h02, oe_lat, rsp_lat, oe_cyc, d, e, va);
        vectors++;
        if (d !== 16'h0003 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL after_div0: got %h err %b, required 0003 err 0", d, e);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  cmds [5] = '{4'h1, 4'h7, 4'h6, 4'h0, 4'h3};
        logic [7:0]  as   [5] = '{8'h09, 8'h81, 8'hF0, 8'hFF, 8'h0A};
        logic [7:0]  bs   [5] = '{8'h04, 8'h00, 8'h3C, 8'h01, 8'h50};
        logic [15:0] exp  [5] = '{16'h0005, 16'h0102, 16'h00CC, 16'h0100, 16'h005A};
        logic [15:0] first;
        logic        stable;
        int n;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(cmds[i], as[i], bs[i]);
        vectors++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: req_ready=%b busy=%b, required 0/1", req_ready, busy);
        end
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        first  = rsp_data;
        stable = rsp_valid;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_data !== first || rsp_err !== 1'b0) stable = 1'b0;
        end
        vectors++;
        if (stable !== 1'b1 || first !== 16'h0005) begin
            miscompares++;
            $display("FAIL bp_stall: stable=%b first=%h, required 1 and 0005", stable, first);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!rsp_valid && n < 40) begin
                tick();
                n++;
            end
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_err !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: valid %b data %h err %b, required 1 %h 0", i, rsp_valid, rsp_data, rsp_err, exp[i]);
            end
            tick();
        end
        repeat (2) tick();
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_idle: busy=%b req_ready=%b rsp_valid=%b, required 0 1 0", busy, req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic stale;
        int n;
        rsp_ready = 1'b1;
        push_op(4'h4, 8'h03, 8'h05);
        push_op(4'h4, 8'h07, 8'h09);
        push_op(4'h4, 8'h11, 8'h02);
        n    = 0;
        seen = alu_oe;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = alu_oe;
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_sample: alu_oe %b before reset, required 1", seen);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (alu_oe !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_async: oe=%b rsp_valid=%b busy=%b, required 0 0 0", alu_oe, rsp_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid || alu_oe || busy) stale = 1'b1;
        end
        vectors++;
        if (stale !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_stale: activity after reset %b, required 0", stale);
        end
    endtask

    task automatic test_push_pop();
        logic [15:0] exp [5] = '{16'h0040, 16'h005A, 16'h0081, 16'h00F0, 16'h0080};
        int n;
        rsp_ready = 1'b0;
        push_op(4'h0, 8'h10, 8'h20);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0030) begin
            miscompares++;
            $display("FAIL pp_first: valid %b data %h, required 1 0030", rsp_valid, rsp_data);
        end
        push_op(4'h1, 8'h50, 8'h10);
        push_op(4'h2, 8'hFF, 8'h5A);
        push_op(4'h3, 8'h01, 8'h80);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pp_three: req_ready %b with 3 queued, required 1", req_ready);
        end
        rsp_ready = 1'b1;
        tick();
        req_cmd   = 4'h6;
        req_a     = 8'h0F;
        req_b     = 8'hFF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL pp_same_edge: req_ready %b after push+pop, required 1", req_ready);
        end
        req_cmd   = 4'h7;
        req_a     = 8'h40;
        req_b     = 8'h00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_count: req_ready %b after one more push, required 0", req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!rsp_valid && n < 40) begin
                tick();
                n++;
            end
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp[i] || rsp_err !== 1'b0) begin
                miscompares++;
                $display("FAIL pp_drain[%0d]: valid %b data %h err %b, required 1 %h 0", i, rsp_valid, rsp_data, rsp_err, exp[i]);
            end
            tick();
        end
        repeat (2) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pp_idle: busy %b, required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_div();
        test_div0();
        test_backpressure();
        test_reset_mid();
        test_push_pop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
